// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Two-flop synchroniser plus independent per-channel debounce FSM
//            for raw push-button pins. Produces a clean level and one-cycle
//            press / release strobes in the clk domain.
// Options  : define BUTTON_DEBOUNCE_REPEAT_EN to add auto-repeat press
//            strobes while a button is held (REPEAT_DELAY, REPEAT_PERIOD).
// Note     : the release strobe port is named release_strobe because
//            'release' is a reserved word in SystemVerilog.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_strobe
);

    // Terminal count: the counter stops here, so it can never wrap.
    localparam logic [CNT_WIDTH-1:0] c_cnt_term = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_st_stable_lo = 2'd0;
    localparam logic [1:0] c_st_check_hi  = 2'd1;
    localparam logic [1:0] c_st_stable_hi = 2'd2;
    localparam logic [1:0] c_st_check_lo  = 2'd3;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    // The repeat counter is sized from the repeat constants themselves so the
    // long default delays fit regardless of the debounce counter width.
    localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rpt_w   = (c_rpt_max > 1) ? $clog2(c_rpt_max) : 1;
    localparam logic [c_rpt_w-1:0] c_rpt_delay_term  = c_rpt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rpt_w-1:0] c_rpt_period_term = c_rpt_w'(REPEAT_PERIOD - 1);
`endif

    logic [N_BUTTONS-1:0] r_s1;
    logic [N_BUTTONS-1:0] r_s2;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= buttons;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        logic [1:0]           r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_level;
        logic                 r_press;
        logic                 r_release;
        logic                 w_rpt_fire;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        logic [c_rpt_w-1:0] r_rpt;
        logic               r_rpt_phase;   // 0: waiting first delay, 1: periodic

        // Repeat strobe request: only while held in STABLE_HI.
        always_comb begin
            w_rpt_fire = 1'b0;
            if (r_state == c_st_stable_hi && r_s2[i]) begin
                w_rpt_fire = r_rpt_phase ? (r_rpt == c_rpt_period_term)
                                         : (r_rpt == c_rpt_delay_term);
            end
        end

        // Repeat counter: held clear outside STABLE_HI, so every entry
        // (initial press or bounce-back from CHECK_LO) restarts the delay.
        always_ff @(posedge clk) begin
            if (!resetn || r_state != c_st_stable_hi || !r_s2[i]) begin
                r_rpt       <= '0;
                r_rpt_phase <= 1'b0;
            end else if (w_rpt_fire) begin
                r_rpt       <= '0;
                r_rpt_phase <= 1'b1;
            end else begin
                r_rpt       <= r_rpt + c_rpt_w'(1);
            end
        end
`else
        assign w_rpt_fire = 1'b0;
`endif

        // Debounce FSM with registered level and strobes.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_state   <= c_st_stable_lo;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rpt_fire;
                r_release <= 1'b0;
                case (r_state)
                    c_st_stable_lo: begin
                        if (r_s2[i]) begin
                            r_state <= c_st_check_hi;
                            r_cnt   <= '0;
                        end
                    end
                    c_st_check_hi: begin
                        if (!r_s2[i]) begin
                            r_state <= c_st_stable_lo;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_cnt_term) begin
                            r_state <= c_st_stable_hi;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + CNT_WIDTH'(1);
                        end
                    end
                    c_st_stable_hi: begin
                        if (!r_s2[i]) begin
                            r_state <= c_st_check_lo;
                            r_cnt   <= '0;
                        end
                    end
                    c_st_check_lo: begin
                        if (r_s2[i]) begin
                            r_state <= c_st_stable_hi;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_cnt_term) begin
                            r_state   <= c_st_stable_lo;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt     <= r_cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_state <= c_st_stable_lo;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign level[i]          = r_level;
        assign press[i]          = r_press;
        assign release_strobe[i] = r_release;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Randomised scoreboard bench for button_debounce. A reference
//            model queues expected levels and strobe events; a monitor pops
//            and compares them against the DUT every cycle.
// Options  : honours BUTTON_DEBOUNCE_REPEAT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int CW = 2;     // smallest width that still holds D-1
    localparam int RD = 10;
    localparam int RP = 5;

    logic         clk     = 1'b0;
    logic         resetn  = 1'b0;
    logic [N-1:0] buttons = '0;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    always #5 clk = ~clk;

    button_debounce #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_WIDTH       (CW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .buttons        (buttons),
        .level          (level),
        .press          (press),
        .release_strobe (rel)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] p;
        logic [N-1:0] r;
    } ev_t;

    ev_t          ev_q[$];
    logic [N-1:0] lvl_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;

    // Reference model: the raw pins reach the decision point two edges late;
    // a level flips once D+1 consecutive delayed samples disagree with it.
    logic [N-1:0] m_d1    = '0;
    logic [N-1:0] m_d2    = '0;
    logic [N-1:0] m_level = '0;
    int           m_run[N]   = '{default: 0};
    int           m_since[N] = '{default: 0};

    always @(posedge clk) begin : model
        logic [N-1:0] v;
        logic [N-1:0] p;
        logic [N-1:0] r;
        cyc++;
        p = '0;
        r = '0;
        if (!resetn) begin
            m_d1    = '0;
            m_d2    = '0;
            m_level = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c]   = 0;
                m_since[c] = 0;
            end
        end else begin
            v    = m_d2;
            m_d2 = m_d1;
            m_d1 = buttons;
            for (int c = 0; c < N; c++) begin
                if (v[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D + 1) begin
                        m_level[c] = v[c];
                        m_run[c]   = 0;
                        m_since[c] = 0;
                        if (v[c]) p[c] = 1'b1;
                        else      r[c] = 1'b1;
                    end
                end else begin
                    if (m_run[c] != 0) begin
                        m_since[c] = 0;          // bounce absorbed, hold time restarts
                    end else if (m_level[c]) begin
                        m_since[c]++;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
                        if (m_since[c] == RD ||
                            (m_since[c] > RD && ((m_since[c] - RD) % RP) == 0))
                            p[c] = 1'b1;
`endif
                    end
                    m_run[c] = 0;
                end
            end
        end
        lvl_q.push_back(m_level);
        if (p != '0 || r != '0) ev_q.push_back('{cyc, p, r});
    end

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin : monitor
        ev_t          e;
        logic [N-1:0] lv;
        #1;
        checks++;
        if (lvl_q.size() == 0) begin
            errors++;
            $display("FAIL level_queue_empty cyc=%0d", cyc);
        end else begin
            lv = lvl_q.pop_front();
            if (level !== lv) begin
                errors++;
                $display("FAIL level cyc=%0d got=%b exp=%b", cyc, level, lv);
            end
        end
        checks++;
        if ((press & rel) !== '0) begin
            errors++;
            $display("FAIL press_release_overlap cyc=%0d press=%b release=%b", cyc, press, rel);
        end
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            e = ev_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_strobe cyc=%0d exp_press=%b exp_release=%b", e.cyc, e.p, e.r);
        end
        if ((press | rel) !== '0) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b", cyc, press, rel);
            end else begin
                e = ev_q.pop_front();
                if (e.cyc != cyc || e.p !== press || e.r !== rel) begin
                    errors++;
                    $display("FAIL strobe cyc=%0d got press=%b release=%b exp cyc=%0d press=%b release=%b",
                             cyc, press, rel, e.cyc, e.p, e.r);
                end
            end
        end
    end

    task automatic hold(input logic [N-1:0] b, input int n);
        buttons = b;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        // Simultaneous press with long hold, then release channel 1 only.
        hold(2'b11, 30);
        hold(2'b01, 20);
        hold(2'b00, 15);
        // Short pulse and single-cycle glitch, both absorbed.
        hold(2'b01, 3);  hold(2'b00, 10);
        hold(2'b01, 1);  hold(2'b00, 10);
        // Press, then release with bounce.
        hold(2'b01, 12);
        hold(2'b00, 1); hold(2'b01, 1); hold(2'b00, 1); hold(2'b01, 1);
        hold(2'b00, 15);
        // Reset while mid-debounce with the button held through it.
        hold(2'b01, 4);
        resetn = 1'b0;
        hold(2'b01, 2);
        resetn = 1'b1;
        hold(2'b01, 20);
        hold(2'b00, 15);
        // Randomised segments: mostly short bounces, some long holds.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 60) == 0) resetn = 1'b0;
            else                            resetn = 1'b1;
            hold(N'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 30))
                                             : int'($urandom_range(1, 6)));
        end
        resetn = 1'b1;
        hold(2'b00, 40);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got=%0d exp=0", ev_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
